// File: rtl/usb_slave_fifo_model_if.sv
// Strobe, flag, host-stream and error signals between the FPGA-side USB master
// and the slave-FIFO responder. The 16-bit data bus stays a plain inout port.
interface usb_slave_fifo_model_if;
    logic [1:0]  usb_fifoaddr;
    logic        usb_slcs;
    logic        usb_sloe;
    logic        usb_slrd;
    logic        usb_slwr;
    logic        usb_flaga;
    logic        usb_flagb;
    logic        usb_flagc;
    logic        host_wr_valid;
    logic [15:0] host_wr_data;
    logic        host_wr_ready;
    logic        host_rd_valid;
    logic [15:0] host_rd_data;
    logic        host_rd_ready;
    logic        err_clr;
    logic [3:0]  err;

    modport master (
        output usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd, usb_slwr,
        output host_wr_valid, host_wr_data, host_rd_ready, err_clr,
        input  usb_flaga, usb_flagb, usb_flagc,
        input  host_wr_ready, host_rd_valid, host_rd_data, err
    );

    modport slave (
        input  usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd, usb_slwr,
        input  host_wr_valid, host_wr_data, host_rd_ready, err_clr,
        output usb_flaga, usb_flagb, usb_flagc,
        output host_wr_ready, host_rd_valid, host_rd_data, err
    );
endinterface

// File: rtl/usb_slave_fifo_model.sv
// CY68013 slave-FIFO responder: EP2 OUT FIFO fed from the host stream and read by
// the USB master, EP6 IN FIFO written by the USB master and drained to the host.
module usb_slave_fifo_model #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                  fpga_gclk,
    input  logic                  reset_n,
    usb_slave_fifo_model_if.slave bus,
    inout  wire  [15:0]           usb_fd
);

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        RD_ACTIVE = 2'd1,
        WR_ACTIVE = 2'd2
    } bus_state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    bus_state_t    state;
    logic          slrd_q;
    logic          slwr_q;
    logic          bus_rst_q;

    logic [15:0]   ep2_mem [DEPTH];
    logic [15:0]   ep6_mem [DEPTH];
    logic [AW-1:0] ep2_wptr;
    logic [AW-1:0] ep2_rptr;
    logic [AW-1:0] ep6_wptr;
    logic [AW-1:0] ep6_rptr;
    logic [AW:0]   ep2_cnt;
    logic [AW:0]   ep6_cnt;

    logic          cs_act;
    logic          rd_edge;
    logic          wr_edge;
    logic          rd_go;
    logic          wr_go;
    logic          addr_ep2;
    logic          addr_ep6;
    logic          addr_bad;
    logic          ep2_empty;
    logic          ep2_full;
    logic          ep6_empty;
    logic          ep6_full;
    logic          ep2_push;
    logic          ep2_pop;
    logic          ep6_push;
    logic          ep6_pop;
    logic [3:0]    err_set;
    logic          fd_drive;
    logic [15:0]   fd_value;

    assign cs_act    = ~bus.usb_slcs;
    assign rd_edge   = ~slrd_q & bus.usb_slrd & cs_act;
    assign wr_edge   = ~slwr_q & bus.usb_slwr & cs_act;
    // A rising strobe only counts when the FSM saw the matching falling edge first.
    assign rd_go     = rd_edge & (state == RD_ACTIVE);
    assign wr_go     = wr_edge & (state == WR_ACTIVE);

    assign addr_ep2  = (bus.usb_fifoaddr == 2'b00);
    assign addr_ep6  = (bus.usb_fifoaddr == 2'b10);
    assign addr_bad  = bus.usb_fifoaddr[0];

    assign ep2_empty = (ep2_cnt == '0);
    assign ep2_full  = (ep2_cnt == FULL_CNT);
    assign ep6_empty = (ep6_cnt == '0);
    assign ep6_full  = (ep6_cnt == FULL_CNT);

    assign ep2_push  = bus.host_wr_valid & ~ep2_full;
    assign ep2_pop   = rd_go & addr_ep2 & ~ep2_empty;
    assign ep6_push  = wr_go & addr_ep6 & ~ep6_full;
    assign ep6_pop   = bus.host_rd_ready & ~ep6_empty;

    assign err_set[0] = rd_go & addr_ep2 & ep2_empty;
    assign err_set[1] = wr_go & addr_ep6 & ep6_full;
    assign err_set[2] = cs_act & ~bus.usb_sloe & ~bus.usb_slwr;
    assign err_set[3] = (rd_go | wr_go) & addr_bad;

    // Host-side handshakes come straight from the registered counts.
    assign bus.host_wr_ready = ~ep2_full;
    assign bus.host_rd_valid = ~ep6_empty;
    assign bus.host_rd_data  = ep6_empty ? 16'h0000 : ep6_mem[ep6_rptr];
    assign bus.usb_flagb     = 1'b0;

    // bus_rst_q keeps the data bus released while reset is being applied.
    assign fd_drive = cs_act & ~bus.usb_sloe & addr_ep2 & ~bus_rst_q;
    assign fd_value = ep2_empty ? 16'h0000 : ep2_mem[ep2_rptr];
    assign usb_fd   = fd_drive ? fd_value : 16'hzzzz;

    always_ff @(posedge fpga_gclk) begin
        bus_rst_q <= ~reset_n;
    end

    always_ff @(posedge fpga_gclk) begin
        if (!reset_n) begin
            slrd_q <= 1'b1;
            slwr_q <= 1'b1;
        end else begin
            slrd_q <= bus.usb_slrd;
            slwr_q <= bus.usb_slwr;
        end
    end

    always_ff @(posedge fpga_gclk) begin
        if (!reset_n || bus.usb_slcs) begin
            state <= BUS_IDLE;
        end else begin
            case (state)
                BUS_IDLE: begin
                    if (!bus.usb_slrd) begin
                        state <= RD_ACTIVE;
                    end else if (!bus.usb_slwr) begin
                        state <= WR_ACTIVE;
                    end
                end
                RD_ACTIVE: if (rd_edge) state <= BUS_IDLE;
                WR_ACTIVE: if (wr_edge) state <= BUS_IDLE;
                default:   state <= BUS_IDLE;
            endcase
        end
    end

    always_ff @(posedge fpga_gclk) begin
        if (!reset_n) begin
            ep2_wptr <= '0;
            ep2_rptr <= '0;
            ep2_cnt  <= '0;
            ep6_wptr <= '0;
            ep6_rptr <= '0;
            ep6_cnt  <= '0;
        end else begin
            if (ep2_push) ep2_wptr <= ep2_wptr + AW'(1);
            if (ep2_pop)  ep2_rptr <= ep2_rptr + AW'(1);
            if (ep6_push) ep6_wptr <= ep6_wptr + AW'(1);
            if (ep6_pop)  ep6_rptr <= ep6_rptr + AW'(1);
            ep2_cnt <= ep2_cnt + (AW+1)'(ep2_push) - (AW+1)'(ep2_pop);
            ep6_cnt <= ep6_cnt + (AW+1)'(ep6_push) - (AW+1)'(ep6_pop);
        end
    end

    // Storage carries no reset; emptiness is tracked by the counts alone.
    always_ff @(posedge fpga_gclk) begin
        if (ep2_push) ep2_mem[ep2_wptr] <= bus.host_wr_data;
        if (ep6_push) ep6_mem[ep6_wptr] <= usb_fd;
    end

    always_ff @(posedge fpga_gclk) begin
        if (!reset_n) begin
            bus.usb_flaga <= 1'b0;
            bus.usb_flagc <= 1'b1;
        end else begin
            bus.usb_flaga <= ~ep2_empty;
            bus.usb_flagc <= ~ep6_full;
        end
    end

    // A new error event on the same cycle as err_clr survives the clear.
    always_ff @(posedge fpga_gclk) begin
        if (!reset_n) begin
            bus.err <= 4'h0;
        end else if (bus.err_clr) begin
            bus.err <= err_set;
        end else begin
            bus.err <= bus.err | err_set;
        end
    end

endmodule

// File: tb/tb_usb_slave_fifo_model.sv
// Bench for usb_slave_fifo_model: master-side strobe sequences and host streams
// checked against queue-based models of EP2, EP6 and the sticky error flags.
module tb_usb_slave_fifo_model;
    logic        fpga_gclk = 1'b0;
    logic        reset_n   = 1'b0;
    wire  [15:0] usb_fd;
    logic        fd_oe     = 1'b0;
    logic [15:0] fd_drv    = 16'h0000;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] ep2_q[$];
    logic [15:0] ep6_q[$];
    logic [3:0]  err_m = 4'h0;

    assign usb_fd = fd_oe ? fd_drv : 16'hzzzz;

    usb_slave_fifo_model_if bus_if();

    usb_slave_fifo_model #(.DEPTH(16), .AW(4)) dut (
        .fpga_gclk (fpga_gclk),
        .reset_n   (reset_n),
        .bus       (bus_if),
        .usb_fd    (usb_fd)
    );

    always #10 fpga_gclk = ~fpga_gclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge fpga_gclk);
    endtask

    function automatic logic [15:0] ep2_head();
        return (ep2_q.size() > 0) ? ep2_q[0] : 16'h0000;
    endfunction

    function automatic logic [15:0] ep6_head();
        return (ep6_q.size() > 0) ? ep6_q[0] : 16'h0000;
    endfunction

    // One idle cycle lets the registered flags catch up, then compare everything.
    task automatic settle_chk(input string tag);
        cyc(1);
        #1;
        check_val({tag, ":flaga"},  32'(bus_if.usb_flaga),     32'(ep2_q.size() != 0));
        check_val({tag, ":flagb"},  32'(bus_if.usb_flagb),     32'(0));
        check_val({tag, ":flagc"},  32'(bus_if.usb_flagc),     32'(ep6_q.size() != 16));
        check_val({tag, ":wr_rdy"}, 32'(bus_if.host_wr_ready), 32'(ep2_q.size() != 16));
        check_val({tag, ":rd_vld"}, 32'(bus_if.host_rd_valid), 32'(ep6_q.size() != 0));
        check_val({tag, ":rd_dat"}, 32'(bus_if.host_rd_data),  32'(ep6_head()));
        check_val({tag, ":err"},    32'(bus_if.err),           32'(err_m));
    endtask

    task automatic host_push(input logic [15:0] data);
        check_val("push_ready", 32'(bus_if.host_wr_ready), 32'(ep2_q.size() < 16));
        bus_if.host_wr_valid = 1'b1;
        bus_if.host_wr_data  = data;
        cyc(1);
        bus_if.host_wr_valid = 1'b0;
        if (ep2_q.size() < 16) ep2_q.push_back(data);
    endtask

    task automatic host_pop();
        check_val("pop_valid", 32'(bus_if.host_rd_valid), 32'(ep6_q.size() > 0));
        check_val("pop_data",  32'(bus_if.host_rd_data),  32'(ep6_head()));
        bus_if.host_rd_ready = 1'b1;
        cyc(1);
        bus_if.host_rd_ready = 1'b0;
        if (ep6_q.size() > 0) void'(ep6_q.pop_front());
    endtask

    task automatic usb_read(input logic [1:0] addr, input int width, output logic [15:0] word);
        word = 16'h0000;
        bus_if.usb_fifoaddr = addr;
        bus_if.usb_slcs     = 1'b0;
        bus_if.usb_sloe     = 1'b0;
        bus_if.usb_slrd     = 1'b0;
        for (int i = 0; i < width + 1; i++) begin
            if (i > 0) @(negedge fpga_gclk);
            if (i == width) bus_if.usb_slrd = 1'b1;
            #1;
            if (addr == 2'b00) check_val("rd_fd", 32'(usb_fd), 32'(ep2_head()));
        end
        @(negedge fpga_gclk);
        if (addr == 2'b00) begin
            if (ep2_q.size() > 0) word = ep2_q.pop_front();
            else err_m[0] = 1'b1;
        end else if (addr[0]) begin
            err_m[3] = 1'b1;
        end
        bus_if.usb_slcs = 1'b1;
        bus_if.usb_sloe = 1'b1;
    endtask

    task automatic usb_write(input logic [1:0] addr, input logic [15:0] data, input int width,
                             input logic oe_low);
        bus_if.usb_fifoaddr = addr;
        bus_if.usb_slcs     = 1'b0;
        bus_if.usb_sloe     = ~oe_low;
        bus_if.usb_slwr     = 1'b0;
        fd_drv              = data;
        fd_oe               = 1'b1;
        cyc(width);
        bus_if.usb_slwr     = 1'b1;
        cyc(1);
        if (oe_low) err_m[2] = 1'b1;
        if (addr == 2'b10) begin
            if (ep6_q.size() < 16) ep6_q.push_back(data);
            else err_m[1] = 1'b1;
        end else if (addr[0]) begin
            err_m[3] = 1'b1;
        end
        bus_if.usb_slcs = 1'b1;
        bus_if.usb_sloe = 1'b1;
        fd_oe           = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] batch[$];
        int          sent;
        int          k;

        bus_if.usb_fifoaddr  = 2'b00;
        bus_if.usb_slcs      = 1'b1;
        bus_if.usb_sloe      = 1'b1;
        bus_if.usb_slrd      = 1'b1;
        bus_if.usb_slwr      = 1'b1;
        bus_if.host_wr_valid = 1'b0;
        bus_if.host_wr_data  = 16'h0000;
        bus_if.host_rd_ready = 1'b0;
        bus_if.err_clr       = 1'b0;

        // Reset values
        cyc(3);
        settle_chk("reset");
        reset_n = 1'b1;
        cyc(2);

        // Single EP2 read through the master port
        host_push(16'hA5A5);
        bus_if.usb_slcs = 1'b0;
        fd_drv = 16'hC3C3;
        fd_oe  = 1'b1;
        #1;
        check_val("fd_release_oe_high", 32'(usb_fd), 32'h0000C3C3);
        fd_oe = 1'b0;
        bus_if.usb_slcs = 1'b1;
        cyc(1);
        usb_read(2'b00, 9, w);
        check_val("rd_word", 32'(w), 32'h0000A5A5);
        check_val("flaga_hold", 32'(bus_if.usb_flaga), 32'(1));
        cyc(1);
        check_val("flaga_low", 32'(bus_if.usb_flaga), 32'(0));
        check_val("err_clean", 32'(bus_if.err), 32'(0));

        // EP6 write seen on the host pop port
        usb_write(2'b10, 16'h1234, 9, 1'b0);
        cyc(1);
        check_val("ep6_vld", 32'(bus_if.host_rd_valid), 32'(1));
        check_val("ep6_dat", 32'(bus_if.host_rd_data), 32'h00001234);
        host_pop();
        settle_chk("ep6_single");

        // Fill EP6, overflow, then free one slot
        for (int i = 0; i < 16; i++) usb_write(2'b10, 16'($urandom), $urandom_range(1, 3), 1'b0);
        settle_chk("ep6_full");
        usb_write(2'b10, 16'hDEAD, 2, 1'b0);
        settle_chk("ep6_overflow");
        host_pop();
        settle_chk("ep6_one_free");
        while (ep6_q.size() > 0) host_pop();
        settle_chk("ep6_drained");

        // Empty EP2 read and error clear
        usb_read(2'b00, 2, w);
        settle_chk("ep2_underflow");
        bus_if.err_clr = 1'b1;
        cyc(1);
        bus_if.err_clr = 1'b0;
        err_m = 4'h0;
        settle_chk("err_cleared");

        // Host push and USB pop on EP2 in the same cycle at count 3
        for (int i = 0; i < 3; i++) host_push(16'($urandom));
        settle_chk("ep2_three");
        bus_if.usb_fifoaddr = 2'b00;
        bus_if.usb_slcs = 1'b0;
        bus_if.usb_sloe = 1'b0;
        bus_if.usb_slrd = 1'b0;
        cyc(1);
        #1;
        check_val("conc_fd", 32'(usb_fd), 32'(ep2_head()));
        w = 16'($urandom);
        bus_if.usb_slrd      = 1'b1;
        bus_if.host_wr_valid = 1'b1;
        bus_if.host_wr_data  = w;
        cyc(1);
        bus_if.host_wr_valid = 1'b0;
        bus_if.usb_slcs = 1'b1;
        bus_if.usb_sloe = 1'b1;
        void'(ep2_q.pop_front());
        ep2_q.push_back(w);
        check_val("conc_flaga0", 32'(bus_if.usb_flaga), 32'(1));
        cyc(1);
        check_val("conc_flaga1", 32'(bus_if.usb_flaga), 32'(1));
        for (int i = 0; i < 3; i++) usb_read(2'b00, $urandom_range(1, 4), w);
        settle_chk("conc_drained");

        // Randomized 40-word loopback EP2 -> EP6, wrapping both FIFOs
        sent = 0;
        while (sent < 40) begin
            k = $urandom_range(1, 12);
            if (k > 40 - sent) k = 40 - sent;
            for (int i = 0; i < k; i++) host_push(16'($urandom));
            batch.delete();
            for (int i = 0; i < k; i++) begin
                usb_read(2'b00, $urandom_range(1, 5), w);
                batch.push_back(w);
            end
            for (int i = 0; i < k; i++) usb_write(2'b10, batch[i], $urandom_range(1, 5), 1'b0);
            for (int i = 0; i < k; i++) host_pop();
            sent += k;
        end
        settle_chk("loopback");

        // Bad endpoint address and bus contention
        host_push(16'h0F0F);
        usb_read(2'b01, 2, w);
        settle_chk("bad_addr_rd");
        usb_write(2'b11, 16'h7777, 2, 1'b0);
        settle_chk("bad_addr_wr");
        bus_if.err_clr = 1'b1;
        cyc(1);
        bus_if.err_clr = 1'b0;
        err_m = 4'h0;
        usb_write(2'b10, 16'hBEEF, 3, 1'b1);
        settle_chk("contention");
        host_pop();

        // Reset applied in the middle of a read
        host_push(16'h5555);
        bus_if.usb_fifoaddr = 2'b00;
        bus_if.usb_slcs = 1'b0;
        bus_if.usb_sloe = 1'b0;
        bus_if.usb_slrd = 1'b0;
        cyc(1);
        #1;
        check_val("pre_rst_fd", 32'(usb_fd), 32'(ep2_head()));
        reset_n = 1'b0;
        cyc(1);
        ep2_q.delete();
        ep6_q.delete();
        err_m = 4'h0;
        fd_drv = 16'hC3C3;
        fd_oe  = 1'b1;
        #1;
        check_val("rst_fd_release", 32'(usb_fd), 32'h0000C3C3);
        check_val("rst_flaga", 32'(bus_if.usb_flaga), 32'(0));
        check_val("rst_wr_rdy", 32'(bus_if.host_wr_ready), 32'(1));
        check_val("rst_rd_vld", 32'(bus_if.host_rd_valid), 32'(0));
        fd_oe = 1'b0;
        bus_if.usb_slcs = 1'b1;
        bus_if.usb_sloe = 1'b1;
        bus_if.usb_slrd = 1'b1;
        reset_n = 1'b1;
        cyc(2);
        settle_chk("post_rst");
        host_push(16'h6666);
        usb_read(2'b00, 2, w);
        check_val("post_rst_word", 32'(w), 32'h00006666);
        settle_chk("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_slave_fifo_model.md
# usb_slave_fifo_model

Synthesizable responder for the CY68013 slave-FIFO port: it plays the FX2 side that the FPGA-side USB master talks to. It holds an EP2 OUT FIFO, loaded from a host-side stream, and an EP6 IN FIFO, drained to a host-side stream. It answers the master's asynchronous strobes (usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_fifoaddr) and drives usb_flaga, usb_flagb and usb_flagc. Its uses are board-less loopback of the image-capture USB path and a cycle-accurate bench partner for the master.

## Interface
- DEPTH, 16: entries per FIFO (EP2 and EP6). Must be a power of two, minimum 2.
- AW, 4: log2(DEPTH).
- fpga_gclk  in  1  system clock (50 MHz); all logic on its rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- usb_fifoaddr  in  2  endpoint select: 00 = EP2, 10 = EP6; 01 and 11 unsupported.
- usb_slcs  in  1  chip select, active-low.
- usb_sloe  in  1  data output enable, active-low.
- usb_slrd  in  1  read strobe, active-low.
- usb_slwr  in  1  write strobe, active-low.
- usb_fd  inout  16  data bus.
- usb_flaga  out  1  1 = EP2 not empty.
- usb_flagb  out  1  EP4 not empty; EP4 is unimplemented, so this output is held at 0.
- usb_flagc  out  1  1 = EP6 not full.
- host_wr_valid  in  1, host_wr_data  in  16, host_wr_ready  out  1: push port into EP2. host_wr_ready = EP2 not full.
- host_rd_valid  out  1, host_rd_data  out  16, host_rd_ready  in  1: pop port out of EP6. host_rd_valid = EP6 not empty; host_rd_data = EP6 head.
- err_clr  in  1  clears err. Single-cycle pulse.
- err  out  4  sticky error flags: [0] EP2 underflow, [1] EP6 overflow, [2] bus contention, [3] bad address.

## Operation
- Strobe tracking: slrd_q and slwr_q are the registered previous values of usb_slrd and usb_slwr.
  - Read edge = slrd_q==0 && usb_slrd==1 && usb_slcs==0.
  - Write edge = slwr_q==0 && usb_slwr==1 && usb_slcs==0.
  - Strobe edges are ignored while usb_slcs==1.
- State machine, one-hot or binary.
  - BUS_IDLE:
    - usb_slrd falls while usb_slcs==0 -> RD_ACTIVE.
    - usb_slwr falls while usb_slcs==0 -> WR_ACTIVE.
  - RD_ACTIVE: the read edge pops one word and returns to BUS_IDLE.
  - WR_ACTIVE: the write edge pushes one word and returns to BUS_IDLE.
  - Reset and any usb_slcs==1 cycle force BUS_IDLE.
- Bus drive (combinational): drive usb_fd when usb_slcs==0 && usb_sloe==0 && usb_fifoaddr==00. Otherwise usb_fd is 16'bz.
  - Driven value = EP2 head when EP2 is non-empty, 16'h0000 when empty.
- EP2 pop: on a read edge with fifoaddr==00 and EP2 non-empty, advance the read pointer.
  - Read edge with EP2 empty: no pop; set err[0].
- EP6 push: on a write edge with fifoaddr==10, write the usb_fd value sampled in the edge cycle.
  - Write edge with EP6 full: word dropped; set err[1].
- Strobe edge with fifoaddr 01 or 11: no FIFO action; set err[3].
- Contention: usb_slcs==0 && usb_sloe==0 && usb_slwr==0 in the same cycle sets err[2]. The write still executes.
- Host side:
  - Push into EP2 when host_wr_valid && host_wr_ready.
  - Pop from EP6 when host_rd_valid && host_rd_ready.
- Concurrency: a host push and a USB pop on EP2 in the same cycle both take effect, and the count is unchanged. The same applies to a USB push and a host pop on EP6.
- Pointers are AW bits and wrap modulo DEPTH. Counts are AW+1 bits, range 0..DEPTH.
- err bits set and stay set. err_clr zeroes all bits; if err_clr coincides with a new set, the set wins.

## Timing
- Reset values:
  - Both FIFOs empty; all pointers and counts 0.
  - usb_flaga=0, usb_flagb=0, usb_flagc=1.
  - host_wr_ready=1, host_rd_valid=0, host_rd_data=16'h0000.
  - err=0; state BUS_IDLE; usb_fd released.
  - slrd_q=1, slwr_q=1.
- Reset asserted mid-transfer discards FIFO contents at the next clock edge and releases usb_fd.
- Flags are registered from counts and reflect a push or pop one cycle after the edge cycle. Example: after the last EP2 pop, usb_flaga is low one clock later.
- Read latency: usb_fd shows the EP2 head combinationally once OE conditions hold. The next word appears the cycle after the read edge.
- Minimum strobe low width: 1 clock. Minimum high width between strobes: 1 clock.
- host_wr_ready and host_rd_valid derive from registered counts, with no combinational path from valid/ready inputs.

## Test plan
- Reset, then push 16'hA5A5 via the host port. Master sequence: sloe low, slrd low 9 cycles, slrd high. Required: usb_fd == 16'hA5A5 while slrd is low; usb_flaga returns to 0 one cycle after the rising edge; err==0.
- EP6 write: fifoaddr=10, usb_fd=16'h1234, slwr low 9 cycles then high. Required: host_rd_valid=1 and host_rd_data=16'h1234 two cycles after slwr rises.
- Fill EP6 with 16 writes. Required: usb_flagc=0. A 17th write is dropped and sets err[1]; after one host pop, usb_flagc=1.
- Read edge with EP2 empty -> usb_fd=16'h0000, err[0]=1. Then pulse err_clr -> err=0.
- Simultaneous host push and USB pop on EP2 at count 3 -> count stays 3 and usb_flaga stays 1. Run a 40-word loopback EP2 -> EP6 covering pointer wrap: data order preserved.
- Strobe edge with fifoaddr=01 -> err[3]=1 and no FIFO change. Assert reset_n low mid-read -> usb_fd=z and both FIFOs empty after one clock.
